if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RISC-V pipeline: owns the program counter, drives the instruction-memory request, and produces the IF/ID pipeline register. It consumes StallF, StallD and FlushD from the hazard unit, and PCSrcE/PCTargetE from execute. It tolerates multi-cycle instruction memory by inserting bubbles into decode. It discards stale responses after a redirect.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/if_id_reg.sv | 56 +++++
 rtl/if_stage.sv | 162 ++++++++++++++++
 tb/tb_if_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline front end.
//   XLEN_DEFAULT  : default datapath width
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0) used for pipeline bubbles
//   fetch_state_t : fetch sequencer states
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Update priority: reset > flush > stall > load > bubble.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   flush                   : load a bubble (NOP, PC 0, not valid)
//   stall                   : hold current contents
//   load                    : fetch_instr/fetch_pc are a real instruction this cycle
//   fetch_instr, fetch_pc   : instruction and its PC from the fetch stage
//   instr, pc, pc_plus4     : registered instruction, PC and PC+4 for decode
//   valid                   : registered contents are a real instruction
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  logic [31:0]     fetch_instr,
    input  logic [XLEN-1:0] fetch_pc,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= NOP_INSTR;
            pc       <= '0;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr    <= NOP_INSTR;
            pc       <= '0;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                instr    <= fetch_instr;
                pc       <= fetch_pc;
                pc_plus4 <= fetch_pc + XLEN'(4);
                valid    <= 1'b1;
            end else begin
                // Bubble carries the same encoding as a flush.
                instr    <= NOP_INSTR;
                pc       <= '0;
                pc_plus4 <= '0;
                valid    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, instruction-memory request and the
// IF/ID register. Tolerates multi-cycle memory by bubbling decode, buffers one
// response while fetch is stalled, and discards the stale response of a request
// that was outstanding when a redirect arrived.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   StallF, StallD, FlushD     : hazard-unit controls
//   PCSrcE, PCTargetE          : redirect from execute
//   ImemReq, ImemAddr          : fetch request and word-aligned address
//   ImemRdata, ImemValid       : fetch response (valid may be same cycle as request)
//   InstrD, PCD, PCPlus4D      : IF/ID register contents
//   ValidD                     : IF/ID holds a real instruction
//   FetchCnt, BubbleCnt        : performance counters, present only when the
//                                IF_STAGE_PERF_EN macro is defined
module if_stage
    import riscv_pkg::*;
#(
    parameter int unsigned      XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic [31:0]     ImemRdata,
    input  logic            ImemValid,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [31:0]     FetchCnt,
    output logic [31:0]     BubbleCnt
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] pend_addr_q, pend_addr_d;
    logic            buf_valid_q, buf_valid_d;
    logic [31:0]     buf_instr_q, buf_instr_d;

    logic            deliver;
    logic [31:0]     deliver_instr;

    // No request while the buffer holds an undelivered instruction.
    assign ImemReq  = ((state_q == FETCH) && !buf_valid_q) || (state_q == DROP);
    // In DROP the old address stays on the bus until its response is absorbed.
    assign ImemAddr = (state_q == DROP) ? pend_addr_q : pcf_q;

    always_comb begin
        state_d       = state_q;
        pcf_d         = pcf_q;
        pend_addr_d   = pend_addr_q;
        buf_valid_d   = buf_valid_q;
        buf_instr_d   = buf_instr_q;
        deliver       = 1'b0;
        deliver_instr = NOP_INSTR;

        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (PCSrcE) begin
                    // Request still in flight: its response must be thrown away.
                    if (!buf_valid_q && !ImemValid) begin
                        pend_addr_d = pcf_q;
                        state_d     = DROP;
                    end
                end else if (buf_valid_q) begin
                    if (!StallF) begin
                        deliver       = 1'b1;
                        deliver_instr = buf_instr_q;
                        buf_valid_d   = 1'b0;
                    end
                end else if (ImemValid) begin
                    if (!StallF) begin
                        deliver       = 1'b1;
                        deliver_instr = ImemRdata;
                    end else begin
                        buf_valid_d = 1'b1;
                        buf_instr_d = ImemRdata;
                    end
                end
            end
            DROP: begin
                if (ImemValid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase

        // Redirect wins over stall and over any delivery this cycle.
        if (PCSrcE) begin
            pcf_d       = {PCTargetE[XLEN-1:2], 2'b00};
            buf_valid_d = 1'b0;
        end else if (deliver) begin
            pcf_d = pcf_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            pcf_q       <= RESET_PC;
            pend_addr_q <= RESET_PC;
            buf_valid_q <= 1'b0;
            buf_instr_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pcf_q       <= pcf_d;
            pend_addr_q <= pend_addr_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    if_id_reg #(
        .XLEN (XLEN)
    ) u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (FlushD),
        .stall       (StallD),
        .load        (deliver),
        .fetch_instr (deliver_instr),
        .fetch_pc    (pcf_q),
        .instr       (InstrD),
        .pc          (PCD),
        .pc_plus4    (PCPlus4D),
        .valid       (ValidD)
    );

`ifdef IF_STAGE_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    // Only cycles where IF/ID actually updates with a load or a bubble count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else if (!FlushD && !StallD) begin
            if (deliver) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end else begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign FetchCnt  = fetch_cnt_q;
    assign BubbleCnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by randomized
// hazard/redirect/memory-latency traffic, all checked against a reference model.
module tb_if_stage;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic [31:0] ImemRdata;
    logic        ImemValid;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
`ifdef IF_STAGE_PERF_EN
    logic [31:0] FetchCnt, BubbleCnt;
`endif

    if_stage #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .ImemReq   (ImemReq),
        .ImemAddr  (ImemAddr),
        .ImemRdata (ImemRdata),
        .ImemValid (ImemValid),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
`ifdef IF_STAGE_PERF_EN
        ,
        .FetchCnt  (FetchCnt),
        .BubbleCnt (BubbleCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Instruction memory contents: known word at 0, hashed elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) + 32'h0000_1000;
    endfunction

    // Reference model: fetch progress as "who is owed what" rather than states.
    bit          m_boot;       // first cycle after reset: nothing requested
    bit          m_discard;    // one response still owed to a cancelled request
    logic [31:0] m_pc;
    logic [31:0] m_old;
    logic [31:0] m_buf[$];
    logic [31:0] e_instr, e_pc, e_pc4;
    bit          e_valid;
    logic [31:0] m_fetch, m_bubble;

    // Stimulus knobs for the next step.
    bit          s_stallf, s_stalld, s_flushd, s_pcsrc, s_force_valid;
    logic [31:0] s_target;
    int          lat_fixed;    // <0 selects random latency

    // Memory latency model.
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt, mem_lat;

    task automatic model_reset();
        m_boot    = 1;
        m_discard = 0;
        m_pc      = RESET_PC;
        m_old     = RESET_PC;
        m_buf.delete();
        e_instr   = NOP;
        e_pc      = 0;
        e_pc4     = 0;
        e_valid   = 0;
        m_fetch   = 0;
        m_bubble  = 0;
        mem_busy  = 0;
    endtask

    task automatic clear_knobs();
        s_stallf = 0; s_stalld = 0; s_flushd = 0; s_pcsrc = 0; s_force_valid = 0;
        s_target = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
        ImemValid = 0; ImemRdata = 0;
        model_reset();
        clear_knobs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // One cycle: check outputs against the model, drive inputs, advance the model.
    task automatic step();
        bit          e_req, v, deliver;
        logic [31:0] e_addr, rd, d_instr, d_pc, old_pc;
        @(negedge clk);
        e_req  = !m_boot && (m_discard || m_buf.size() == 0);
        e_addr = m_discard ? m_old : m_pc;
        check("ImemReq", {31'b0, ImemReq}, {31'b0, e_req});
        if (e_req) check("ImemAddr", ImemAddr, e_addr);
        check("InstrD", InstrD, e_instr);
        check("PCD", PCD, e_pc);
        check("PCPlus4D", PCPlus4D, e_pc4);
        check("ValidD", {31'b0, ValidD}, {31'b0, e_valid});
`ifdef IF_STAGE_PERF_EN
        check("FetchCnt", FetchCnt, m_fetch);
        check("BubbleCnt", BubbleCnt, m_bubble);
`endif
        v = 0;
        if (ImemReq) begin
            if (!mem_busy || ImemAddr != mem_addr) begin
                mem_busy = 1;
                mem_addr = ImemAddr;
                mem_cnt  = 0;
                if (lat_fixed >= 0) mem_lat = lat_fixed;
                else mem_lat = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 3));
            end
            if (mem_cnt >= mem_lat) begin
                v = 1;
                mem_busy = 0;
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_busy = 0;
            v = s_force_valid;
        end
        rd = v ? mem_word(ImemAddr) : $urandom();

        StallF    = s_stallf;
        StallD    = s_stalld;
        FlushD    = s_flushd;
        PCSrcE    = s_pcsrc;
        PCTargetE = s_target;
        ImemValid = v;
        ImemRdata = rd;

        deliver = 0;
        d_instr = NOP;
        d_pc    = 0;
        old_pc  = m_pc;
        m_boot  = 0;
        if (m_discard) begin
            if (v) m_discard = 0;
            if (s_pcsrc) m_pc = s_target & ~32'h3;
        end else if (s_pcsrc) begin
            m_pc = s_target & ~32'h3;
            m_buf.delete();
            if (e_req && !v) begin
                m_discard = 1;
                m_old     = old_pc;
            end
        end else if (m_buf.size() > 0) begin
            if (!s_stallf) begin
                deliver = 1;
                d_instr = m_buf.pop_front();
                d_pc    = m_pc;
                m_pc    = m_pc + 4;
            end
        end else if (v && e_req) begin
            if (!s_stallf) begin
                deliver = 1;
                d_instr = rd;
                d_pc    = m_pc;
                m_pc    = m_pc + 4;
            end else begin
                m_buf.push_back(rd);
            end
        end

        if (s_flushd) begin
            e_instr = NOP; e_pc = 0; e_pc4 = 0; e_valid = 0;
        end else if (!s_stalld) begin
            if (deliver) begin
                e_instr = d_instr; e_pc = d_pc; e_pc4 = d_pc + 4; e_valid = 1;
                m_fetch++;
            end else begin
                e_instr = NOP; e_pc = 0; e_pc4 = 0; e_valid = 0;
                m_bubble++;
            end
        end
    endtask

    int seen_pc10;

    initial begin
        rst_n = 0;
        lat_fixed = 0;
        clear_knobs();
        model_reset();

        // Zero-wait memory from reset.
        do_reset();
        lat_fixed = 0;
        step();                                        // cycle 0: BOOT
        check("boot_no_req", {31'b0, ImemReq}, 32'd0);
        step();                                        // cycle 1
        check("c1_addr", ImemAddr, 32'h0);
        step();                                        // cycle 2
        check("c2_instr", InstrD, 32'h0050_0093);
        check("c2_pcd", PCD, 32'h0);
        check("c2_valid", {31'b0, ValidD}, 32'd1);
        check("c2_addr", ImemAddr, 32'h4);
        step();
        check("c3_addr", ImemAddr, 32'h8);
        // Flush and stall together: flush wins.
        s_flushd = 1; s_stalld = 1; s_stallf = 1;
        step();
        clear_knobs();
        step();
        check("flush_instr", InstrD, NOP);
        check("flush_valid", {31'b0, ValidD}, 32'd0);

        // Two-cycle memory.
        do_reset();
        lat_fixed = 1;
        repeat (4) step();                             // cycles 0..3
        check("lat2_c3_addr", ImemAddr, 32'h4);
        step();                                        // cycle 4
        check("lat2_c4_addr", ImemAddr, 32'h4);
        check("lat2_bubble_valid", {31'b0, ValidD}, 32'd0);
        check("lat2_bubble_instr", InstrD, NOP);
        step();                                        // cycle 5
        check("lat2_c5_pcd", PCD, 32'h4);

        // Stall both stages while 0x8 returns.
        do_reset();
        lat_fixed = 0;
        repeat (3) step();                             // cycles 0..2
        s_stallf = 1; s_stalld = 1;
        repeat (2) step();                             // cycles 3..4
        check("stall_no_req", {31'b0, ImemReq}, 32'd0);
        step();                                        // cycle 5
        clear_knobs();
        step();                                        // cycle 6: drain
        step();                                        // cycle 7
        check("drain_instr", InstrD, mem_word(32'h8));
        check("drain_pcd", PCD, 32'h8);
        check("drain_addr", ImemAddr, 32'hC);

        // Redirect while the 0x10 request is outstanding.
        do_reset();
        lat_fixed = 2;
        repeat (13) step();                            // cycles 0..12
        s_pcsrc = 1; s_flushd = 1; s_target = 32'h0000_0103;
        step();                                        // cycle 13
        check("redir_from", ImemAddr, 32'h10);
        clear_knobs();
        step();                                        // cycle 14: DROP
        check("drop_addr", ImemAddr, 32'h10);
        step();                                        // cycle 15
        step();                                        // cycle 16
        check("redir_to", ImemAddr, 32'h100);
        seen_pc10 = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ValidD && PCD == 32'h10) seen_pc10++;
        end
        check("no_stale_pc10", seen_pc10, 0);

        // PC wraparound at the top of the address space.
        do_reset();
        lat_fixed = 0;
        repeat (2) step();
        s_pcsrc = 1; s_target = 32'hFFFF_FFFF;
        step();
        clear_knobs();
        step();
        check("wrap_top", ImemAddr, 32'hFFFF_FFFC);
        step();
        check("wrap_zero", ImemAddr, 32'h0);

        // Asynchronous reset while a request waits; stale response afterwards.
        do_reset();
        lat_fixed = 3;
        repeat (3) step();
        @(posedge clk);
        #2 rst_n = 0;
        ImemValid = 1;
        #1;
        check("arst_req", {31'b0, ImemReq}, 32'd0);
        check("arst_addr", ImemAddr, RESET_PC);
        check("arst_instr", InstrD, NOP);
        check("arst_valid", {31'b0, ValidD}, 32'd0);
        check("arst_pcd", PCD, 32'h0);
        model_reset();
        clear_knobs();
        @(posedge clk);
        #1 rst_n = 1;
        s_force_valid = 1;
        lat_fixed = 0;
        step();                                        // BOOT with stale valid
        s_force_valid = 0;
        step();
        check("arst_restart", ImemAddr, RESET_PC);
        repeat (3) step();

        // Randomized traffic.
        lat_fixed = -1;
        for (int i = 0; i < 3000; i++) begin
            s_stallf = ($urandom_range(0, 99) < 20);
            s_stalld = s_stallf ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 5);
            s_flushd = ($urandom_range(0, 99) < 5);
            s_pcsrc  = ($urandom_range(0, 99) < 7);
            s_target = ($urandom_range(0, 3) == 0) ? $urandom() : {20'h0, 12'($urandom())};
            s_force_valid = 0;
            step();
            if ($urandom_range(0, 599) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
